// File: rtl/endeavour_apb_pkg.sv
// Shared APB arbitration types and helpers.
// Imported by apb_arbiter2 for its FSM state and timeout counter sizing.
package endeavour_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_arb_state_t;

    // Counter width able to hold 0..cycles, never narrower than one bit.
    function automatic int tmo_width(input int cycles);
        if (cycles < 1) begin
            return 1;
        end
        return $clog2(cycles + 1);
    endfunction

    // Round-robin pick between two requesters; last is the most
    // recently served master, so a tie goes to the other one.
    function automatic logic rr_pick(
        input logic req0,
        input logic req1,
        input logic last
    );
        if (req0 && req1) begin
            return !last;
        end
        return req1 && !req0;
    endfunction

endpackage

// File: rtl/apb_arbiter2.sv
// Two-master APB arbiter in front of a single APB slave: round-robin,
// one transfer per grant, optional slave response timeout with PSLVERR.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   m0_* / m1_*         APB completer ports toward the two masters
//                       (PADDR, PSEL, PENABLE, PWRITE, PWDATA in;
//                        PREADY, PRDATA, PSLVERR out)
//   s_*                 APB requester port toward the shared slave
//                       (PADDR, PSEL, PENABLE, PWRITE, PWDATA out;
//                        PREADY, PRDATA in)
module apb_arbiter2
    import endeavour_apb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_PADDR,
    input  logic                  m0_PSEL,
    input  logic                  m0_PENABLE,
    input  logic                  m0_PWRITE,
    input  logic [DATA_WIDTH-1:0] m0_PWDATA,
    output logic                  m0_PREADY,
    output logic [DATA_WIDTH-1:0] m0_PRDATA,
    output logic                  m0_PSLVERR,

    input  logic [ADDR_WIDTH-1:0] m1_PADDR,
    input  logic                  m1_PSEL,
    input  logic                  m1_PENABLE,
    input  logic                  m1_PWRITE,
    input  logic [DATA_WIDTH-1:0] m1_PWDATA,
    output logic                  m1_PREADY,
    output logic [DATA_WIDTH-1:0] m1_PRDATA,
    output logic                  m1_PSLVERR,

    output logic [ADDR_WIDTH-1:0] s_PADDR,
    output logic                  s_PSEL,
    output logic                  s_PENABLE,
    output logic                  s_PWRITE,
    output logic [DATA_WIDTH-1:0] s_PWDATA,
    input  logic                  s_PREADY,
    input  logic [DATA_WIDTH-1:0] s_PRDATA
);

    localparam int TW = tmo_width(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TMO_LAST =
        TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_arb_state_t state;
    apb_arb_state_t state_nxt;
    logic           grant;
    logic           grant_nxt;
    logic           rr_last;
    logic           rr_last_nxt;
    logic [TW-1:0]  tmo_cnt;
    logic [TW-1:0]  tmo_nxt;

    logic           busy;
    logic           in_access;
    logic           tmo_hit;
    logic           done_ok;
    logic           done_tmo;
    logic           g_live;
    logic           resp;
    logic [DATA_WIDTH-1:0] rdata;

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= 1'b0;
            rr_last <= 1'b1;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            rr_last <= rr_last_nxt;
            tmo_cnt <= tmo_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Completion decode
    // ---------------------------------------------------------------
    always_comb begin
        busy      = (state != IDLE);
        in_access = (state == ACCESS);
        tmo_hit   = TMO_EN && (tmo_cnt == TMO_LAST);
        done_ok   = in_access && s_PREADY;
        done_tmo  = in_access && !s_PREADY && tmo_hit;
    end

    // ---------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        rr_last_nxt = rr_last;
        tmo_nxt     = tmo_cnt;
        case (state)
            IDLE: begin
                if (m0_PSEL || m1_PSEL) begin
                    grant_nxt = rr_pick(m0_PSEL, m1_PSEL, rr_last);
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                tmo_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (!s_PREADY) begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
                // A timed-out transfer still counts as this master's
                // turn, so the other master is favoured next.
                if (done_ok || done_tmo) begin
                    rr_last_nxt = grant;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Slave-side request mux
    // ---------------------------------------------------------------
    always_comb begin
        s_PSEL    = busy;
        s_PENABLE = in_access;
        s_PADDR   = '0;
        s_PWRITE  = 1'b0;
        s_PWDATA  = '0;
        if (busy) begin
            s_PADDR  = grant ? m1_PADDR  : m0_PADDR;
            s_PWRITE = grant ? m1_PWRITE : m0_PWRITE;
            s_PWDATA = grant ? m1_PWDATA : m0_PWDATA;
        end
    end

    // ---------------------------------------------------------------
    // Master-side response routing
    // ---------------------------------------------------------------
    // The response is only delivered while the granted master is still
    // in its access phase; a master that abandoned the transfer gets
    // nothing and the slave cycle simply drains.
    always_comb begin
        g_live = grant ? (m1_PSEL && m1_PENABLE)
                       : (m0_PSEL && m0_PENABLE);
        resp   = (done_ok || done_tmo) && g_live;
        rdata  = done_ok ? s_PRDATA : '0;

        m0_PREADY  = 1'b0;
        m0_PRDATA  = '0;
        m0_PSLVERR = 1'b0;
        m1_PREADY  = 1'b0;
        m1_PRDATA  = '0;
        m1_PSLVERR = 1'b0;

        if (resp && !grant) begin
            m0_PREADY  = 1'b1;
            m0_PRDATA  = rdata;
            m0_PSLVERR = done_tmo;
        end
        if (resp && grant) begin
            m1_PREADY  = 1'b1;
            m1_PRDATA  = rdata;
            m1_PSLVERR = done_tmo;
        end
    end

endmodule
